lsu_ctrl: RTL

Load/store controller between the execute stage and the word-organised data memory. It accepts one load or store per request and issues a single memory access with per-byte write strobes. For loads it waits out the memory's one-cycle registered read latency, then extracts the addressed byte or halfword and sign- or zero-extends it. Misaligned and illegal requests are flagged and do not touch memory.

---
 rtl/lsu_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store controller: turns one execute-stage request into a single word-memory access
// with byte-lane strobes, and aligns/extends load data coming back one cycle after mem_re.
module lsu_ctrl #(
    parameter int unsigned bit_size = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                is_load,
    input  logic [2:0]          funct3,
    input  logic [bit_size-1:0] addr,
    input  logic [bit_size-1:0] wdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [bit_size-1:0] rdata,
    output logic [bit_size-1:0] mem_addr,
    output logic [bit_size-1:0] mem_wdata,
    output logic [3:0]          mem_we,
    output logic                mem_re,
    input  logic [bit_size-1:0] mem_rdata
);

    typedef enum logic [2:0] {StIdle, StStReq, StLdReq, StLdWait, StDone} state_e;

    state_e              state_q, state_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [bit_size-1:0] addr_q, addr_d;
    logic                bad_q, bad_d;
    logic [bit_size-1:0] rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                mem_re_q, mem_re_d;
    logic [3:0]          mem_we_q, mem_we_d;
    logic [bit_size-1:0] mem_wdata_q, mem_wdata_d;
    logic [bit_size-1:0] shifted;

    // Misaligned halfword/word, unknown funct3, or an unsigned (load-only) store.
    function automatic logic illegal(input logic ld, input logic [2:0] f, input logic [1:0] o);
        logic bad;
        case (f)
            3'b000:  bad = 1'b0;
            3'b001:  bad = o[0];
            3'b010:  bad = (o != 2'b00);
            3'b100:  bad = !ld;
            3'b101:  bad = !ld || o[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Next state, request latching, load extraction, and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        bad_d    = bad_q;
        rdata_d  = rdata_q;
        shifted  = mem_rdata >> {addr_q[1:0], 3'b000};

        case (state_q)
            StIdle: begin
                if (start) begin
                    funct3_d = funct3;
                    addr_d   = addr;
                    bad_d    = illegal(is_load, funct3, addr[1:0]);
                    if (bad_d)        state_d = StDone;
                    else if (is_load) state_d = StLdReq;
                    else              state_d = StStReq;
                end
            end
            StStReq: state_d = StDone;
            StLdReq: state_d = StLdWait;
            StLdWait: begin
                case (funct3_q)
                    3'b000:  rdata_d = {{(bit_size-8){shifted[7]}}, shifted[7:0]};
                    3'b001:  rdata_d = {{(bit_size-16){shifted[15]}}, shifted[15:0]};
                    3'b100:  rdata_d = {{(bit_size-8){1'b0}}, shifted[7:0]};
                    3'b101:  rdata_d = {{(bit_size-16){1'b0}}, shifted[15:0]};
                    default: rdata_d = mem_rdata;
                endcase
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
        err_d       = done_d && bad_d;
        mem_re_d    = (state_d == StLdReq);
        mem_we_d    = 4'b0000;
        mem_wdata_d = '0;
        if (state_d == StStReq) begin
            case (funct3_d[1:0])
                2'b00: begin
                    mem_we_d    = 4'b0001 << addr_d[1:0];
                    mem_wdata_d = {4{wdata[7:0]}};
                end
                2'b01: begin
                    mem_we_d    = 4'b0011 << addr_d[1:0];
                    mem_wdata_d = {2{wdata[15:0]}};
                end
                default: begin
                    mem_we_d    = 4'b1111;
                    mem_wdata_d = wdata;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            bad_q       <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 4'b0000;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            bad_q       <= bad_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_addr  = {2'b00, addr_q[bit_size-1:2]};

endmodule
